// File: rtl/sw_scan_pkg.sv
// sw_scan_pkg: shared constants, FSM encoding and helpers for the switch scan controller
package sw_scan_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SCAN    = 2'd1;
  localparam logic [1:0] CONFIRM = 2'd2;
  localparam int CH_W       = 4;
  localparam int DEF_CNT1US = 107;
  localparam int DEF_CNT1MS = 1000;
  // A zero-length debounce window is promoted to one millisecond
  function automatic logic [7:0] eff_len(input logic [7:0] l);
    return (l == 8'd0) ? 8'd1 : l;
  endfunction
endpackage

// File: rtl/sw_tick_gen.sv
// sw_tick_gen: clearable prescaler producing us and ms ticks for the shared debounce timer
module sw_tick_gen
  import sw_scan_pkg::*;
#(
  parameter int CNT1US = DEF_CNT1US,
  parameter int CNT1MS = DEF_CNT1MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic us_tick,
  output logic ms_tick
);
  localparam int UW = $clog2(CNT1US + 1);
  localparam int MW = $clog2(CNT1MS + 1);
  logic [UW-1:0] us_div;
  logic [MW-1:0] ms_div;
  assign us_tick = us_div == UW'(CNT1US - 1);
  assign ms_tick = us_tick && ms_div == MW'(CNT1MS - 1);
  // Prescaler chain, held at zero while the timer is not owned by a channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      us_div <= '0;
      ms_div <= '0;
    end else if (clr) begin
      us_div <= '0;
      ms_div <= '0;
    end else begin
      us_div <= us_tick ? '0 : us_div + UW'(1);
      if (us_tick) ms_div <= ms_tick ? '0 : ms_div + MW'(1);
    end
endmodule

// File: rtl/sw_scan_ctrl.sv
// sw_scan_ctrl: round-robin multi-channel switch debouncer sharing one debounce timer
module sw_scan_ctrl
  import sw_scan_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int CNT1US = DEF_CNT1US,
  parameter int CNT1MS = DEF_CNT1MS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CH_NUM-1:0] sw_in,
  input  logic [7:0]        db_len,
  output logic [CH_NUM-1:0] sw_state,
  output logic [CH_NUM-1:0] press_pulse,
  output logic [CH_NUM-1:0] release_pulse,
  output logic              busy,
  output logic [CH_W-1:0]   cur_ch
);
  localparam int PW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  logic [1:0]        state;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [CH_NUM-1:0] sync1, sync2;
  logic              cand;
  logic [7:0]        len, ms_cnt;
  logic              us_tick, ms_tick, ms_evt, abort, commit;
  sw_tick_gen #(.CNT1US(CNT1US), .CNT1MS(CNT1MS)) u_tick (
    .clk(clk), .rst_n(rst_n), .clr(state != CONFIRM), .us_tick(us_tick), .ms_tick(ms_tick)
  );
  assign ms_evt  = us_tick && ms_tick;
  assign ptr_nxt = (ptr == PW'(CH_NUM - 1)) ? '0 : ptr + PW'(1);
  assign abort   = sync2[ptr] != cand;
  assign commit  = !abort && ms_evt && ms_cnt == len - 8'd1;
  assign busy    = state == CONFIRM;
  assign cur_ch  = CH_W'(ptr);
  // Two-stage synchronisers, frozen while scanning is disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else if (en) begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  // Scan FSM: walks channels, confirms a candidate level on the shared timer, commits with a pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      cand          <= 1'b1;
      len           <= 8'd1;
      ms_cnt        <= '0;
      sw_state      <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (!en) begin
        state  <= IDLE;
        ptr    <= '0;
        ms_cnt <= '0;
      end else if (state == IDLE) begin
        state  <= SCAN;
        ptr    <= '0;
        ms_cnt <= '0;
      end else if (state == SCAN) begin
        if (sync2[ptr] == sw_state[ptr]) ptr <= ptr_nxt;
        else begin
          cand   <= sync2[ptr];
          len    <= eff_len(db_len);
          ms_cnt <= '0;
          state  <= CONFIRM;
        end
      end else if (state == CONFIRM) begin
        if (abort || commit) begin
          state <= SCAN;
          ptr   <= ptr_nxt;
        end else if (ms_evt) ms_cnt <= ms_cnt + 8'd1;
        if (commit) begin
          sw_state[ptr] <= cand;
          if (cand) release_pulse[ptr] <= 1'b1;
          else press_pulse[ptr] <= 1'b1;
        end
      end else state <= IDLE;
    end
endmodule
